// File: rtl/uart_boot_sequencer.sv
// UART boot sequencer: decodes ASCII hex into imem words, then starts/stops the CPU on host commands.
// Define BOOT_ECHO_EN to echo every accepted byte and announce a CPU halt with '!'.
module uart_boot_sequencer #(
  parameter int IMEM_DEPTH = 16,
  parameter int NIBBLES    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_rdy,
  output logic                          rx_clr,
  output logic [7:0]                    tx_data,
  output logic                          tx_wr,
  input  logic                          tx_busy,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  input  logic                          cpu_halted,
  output logic                          cpu_start,
  output logic [$clog2(IMEM_DEPTH):0]   words_loaded,
  output logic                          err
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int NW = $clog2(NIBBLES + 1);
  localparam logic [AW:0]   PTR_FULL = (AW+1)'(IMEM_DEPTH);
  localparam logic [NW-1:0] NIB_LAST = NW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_RUN, S_DONE} state_t;

  state_t        r_state, r_state_nxt;
  logic [31:0]   r_word;
  logic [NW-1:0] r_nib;
  logic [AW:0]   r_ptr;
  logic          r_err;
  logic          r_cpu_start;

  logic       w_accept, w_full;
  logic [4:0] w_hex;
  logic       w_shift, w_discard, w_clear, w_set_err, w_inc_ptr;
  logic       w_start_set, w_start_clr, w_enter_done;

  // Returns {valid, nibble}; valid=0 for anything that is not an ASCII hex digit.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

`ifdef BOOT_ECHO_EN
  logic       r_tx_wr;
  logic [7:0] r_tx_data;
  logic       r_bang_pend;
  // The pending '!' takes precedence over new bytes so it is never overtaken by an echo.
  assign w_accept = rx_rdy && !tx_busy && !r_tx_wr && !r_bang_pend && (r_state != S_WRITE);
  assign tx_wr    = r_tx_wr;
  assign tx_data  = r_tx_data;
`else
  logic w_unused;
  assign w_unused = tx_busy;
  assign w_accept = rx_rdy && (r_state != S_WRITE);
  assign tx_wr    = 1'b0;
  assign tx_data  = 8'h00;
`endif

  assign w_hex        = hex_decode(rx_data);
  assign w_full       = (r_ptr == PTR_FULL);
  assign rx_clr       = w_accept;
  assign imem_we      = (r_state == S_WRITE) && !w_full;
  assign imem_addr    = r_ptr[AW-1:0];
  assign imem_wdata   = r_word;
  assign words_loaded = r_ptr;
  assign err          = r_err;
  assign cpu_start    = r_cpu_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt  = r_state;
    w_shift      = 1'b0;
    w_discard    = 1'b0;
    w_clear      = 1'b0;
    w_set_err    = 1'b0;
    w_inc_ptr    = 1'b0;
    w_start_set  = 1'b0;
    w_start_clr  = 1'b0;
    w_enter_done = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (w_hex[4]) begin
            w_shift = 1'b1;
            if (r_nib == NIB_LAST) r_state_nxt = S_WRITE;
          end else if (rx_data == 8'h0A || rx_data == 8'h0D || rx_data == 8'h20) begin
            r_state_nxt = S_LOAD;
          end else if (rx_data == 8'h47) begin
            if (r_nib == '0) begin
              r_state_nxt = S_RUN;
              w_start_set = 1'b1;
            end else begin
              w_set_err = 1'b1;
              w_discard = 1'b1;
            end
          end else if (rx_data == 8'h58) begin
            w_clear = 1'b1;
          end else begin
            w_set_err = 1'b1;
            w_discard = 1'b1;
          end
        end
      end
      S_WRITE: begin
        r_state_nxt = S_LOAD;
        w_discard   = 1'b1;
        if (w_full) w_set_err = 1'b1;
        else        w_inc_ptr = 1'b1;
      end
      S_RUN: begin
        // cpu_start low here means a restart from DONE: halt is stale until the CPU runs again.
        if (w_accept && rx_data == 8'h53) begin
          r_state_nxt = S_LOAD;
          w_start_clr = 1'b1;
        end else if (!r_cpu_start) begin
          w_start_set = 1'b1;
        end else if (cpu_halted) begin
          r_state_nxt  = S_DONE;
          w_enter_done = 1'b1;
        end
      end
      S_DONE: begin
        if (w_accept && rx_data == 8'h53) begin
          r_state_nxt = S_LOAD;
          w_start_clr = 1'b1;
        end else if (w_accept && rx_data == 8'h47) begin
          r_state_nxt = S_RUN;
          w_start_clr = 1'b1;
        end
      end
      default: r_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word      <= '0;
      r_nib       <= '0;
      r_ptr       <= '0;
      r_err       <= 1'b0;
      r_cpu_start <= 1'b0;
    end else begin
      if (w_shift) begin
        r_word <= {r_word[27:0], w_hex[3:0]};
        r_nib  <= r_nib + NW'(1);
      end
      if (w_discard || w_clear) begin
        r_word <= '0;
        r_nib  <= '0;
      end
      if (w_clear)          r_ptr <= '0;
      else if (w_inc_ptr)   r_ptr <= r_ptr + (AW+1)'(1);
      if (w_clear)          r_err <= 1'b0;
      else if (w_set_err)   r_err <= 1'b1;
      if (w_start_set)      r_cpu_start <= 1'b1;
      else if (w_start_clr) r_cpu_start <= 1'b0;
    end
  end

`ifdef BOOT_ECHO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr     <= 1'b0;
      r_tx_data   <= 8'h00;
      r_bang_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tx_wr   <= 1'b1;
        r_tx_data <= rx_data;
      end else if (r_state == S_DONE && r_bang_pend && !tx_busy && !r_tx_wr) begin
        r_tx_wr     <= 1'b1;
        r_tx_data   <= 8'h21;
        r_bang_pend <= 1'b0;
      end else begin
        r_tx_wr <= 1'b0;
      end
      if (w_enter_done) r_bang_pend <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Directed bench for uart_boot_sequencer: a table of load strings plus hand-written run/overflow/flow-control sequences.
module tb_uart_boot_sequencer;

  logic        clk, rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy, rx_clr;
  logic [7:0]  tx_data;
  logic        tx_wr, tx_busy;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_halted, cpu_start;
  logic [4:0]  words_loaded;
  logic        err;

  uart_boot_sequencer #(.IMEM_DEPTH(16), .NIBBLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_clr(rx_clr),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_halted(cpu_halted), .cpu_start(cpu_start),
    .words_loaded(words_loaded), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [3:0]  wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cnt = 0;
  int          tx_cnt = 0;
  int          clr_cnt = 0;
  logic [7:0]  tx_last = 8'h00;

  // Observe one-cycle strobes mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (imem_we && wr_cnt < 64) begin
      wr_addr[wr_cnt] = imem_addr;
      wr_data[wr_cnt] = imem_wdata;
      wr_cnt++;
    end
    if (tx_wr) begin
      tx_last = tx_data;
      tx_cnt++;
    end
    if (rx_clr) clr_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    while (!rx_clr && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      chk("rx_accept_timeout", 32'd0, 32'd1);
      rx_rdy = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_rdy = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  typedef struct {
    string       txt;
    int          writes;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int w0, t0, c0;

    vecs[0] = '{"00100093",          1, 32'h00100093, 1'b0};
    vecs[1] = '{"deadbeef\015\012",  1, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{"0123456789ABCDEF",  2, 32'h89ABCDEF, 1'b0};
    vecs[3] = '{"AbCdEf12 ",         1, 32'hABCDEF12, 1'b0};
    vecs[4] = '{"12Z0000000F",       1, 32'h0000000F, 1'b1};
    vecs[5] = '{"1G",                0, 32'h0,        1'b1};
    vecs[6] = '{"g",                 0, 32'h0,        1'b1};
    vecs[7] = '{"12X3456789a",       1, 32'h3456789A, 1'b0};

    rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; tx_busy = 1'b0; cpu_halted = 1'b0;
    #12;
    chk("rst_cpu_start", 32'(cpu_start), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tx_wr", 32'(tx_wr), 32'd0);
    chk("rst_rx_clr", 32'(rx_clr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Table-driven load strings, each preceded by an 'X' clear.
    for (int v = 0; v < 8; v++) begin
      send("X");
      w0 = wr_cnt;
      send_str(vecs[v].txt);
      idle(3);
      chk($sformatf("vec%0d_writes", v), 32'(wr_cnt - w0), 32'(vecs[v].writes));
      chk($sformatf("vec%0d_words_loaded", v), 32'(words_loaded), 32'(vecs[v].writes));
      chk($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].err));
      if (vecs[v].writes > 0 && wr_cnt > 0)
        chk($sformatf("vec%0d_wdata", v), wr_data[wr_cnt-1], vecs[v].data);
    end

    // Load, run, halt, restart, stop, then resume loading at the retained pointer.
    send("X");
    w0 = wr_cnt;
    send_str("00100093");
    idle(3);
    chk("run_load_addr", 32'(wr_addr[w0]), 32'd0);
    chk("run_load_data", wr_data[w0], 32'h00100093);
    chk("run_load_wl", 32'(words_loaded), 32'd1);
    chk("run_pre_start", 32'(cpu_start), 32'd0);
    send("G");
    chk("run_start_after_g", 32'(cpu_start), 32'd1);
`ifdef BOOT_ECHO_EN
    chk("run_g_echo_wr", 32'(tx_wr), 32'd1);
    chk("run_g_echo_data", 32'(tx_data), 32'h47);
`endif
    w0 = wr_cnt;
    send("a");
    idle(2);
    chk("run_ignore_err", 32'(err), 32'd0);
    chk("run_ignore_nowrite", 32'(wr_cnt - w0), 32'd0);
    t0 = tx_cnt;
    cpu_halted = 1'b1;
    idle(4);
    chk("done_start_held", 32'(cpu_start), 32'd1);
`ifdef BOOT_ECHO_EN
    chk("done_bang_sent", 32'(tx_cnt - t0), 32'd1);
    chk("done_bang_char", 32'(tx_last), 32'h21);
`endif
    send("G");
    chk("restart_low", 32'(cpu_start), 32'd0);
    idle(1);
    chk("restart_high", 32'(cpu_start), 32'd1);
    idle(3);
    send("S");
    chk("stop_from_done", 32'(cpu_start), 32'd0);
    cpu_halted = 1'b0;
    w0 = wr_cnt;
    send_str("0000000F");
    idle(3);
    chk("resume_writes", 32'(wr_cnt - w0), 32'd1);
    chk("resume_addr", 32'(wr_addr[w0]), 32'd1);
    chk("resume_data", wr_data[w0], 32'h0000000F);
    chk("resume_wl", 32'(words_loaded), 32'd2);

    // 'S' and cpu_halted in the same cycle: 'S' wins and the block returns to LOAD.
    send("X");
    send("G");
    idle(2);
    rx_data = "S"; rx_rdy = 1'b1; cpu_halted = 1'b1;
    #1;
    chk("simul_rx_clr", 32'(rx_clr), 32'd1);
    @(posedge clk); #1;
    rx_rdy = 1'b0; cpu_halted = 1'b0;
    chk("simul_start_low", 32'(cpu_start), 32'd0);
    w0 = wr_cnt;
    send_str("00000001");
    idle(3);
    chk("simul_in_load", 32'(wr_cnt - w0), 32'd1);
    if (wr_cnt > w0) chk("simul_data", wr_data[w0], 32'h00000001);

    // Overflow: 17 words into a 16-deep memory.
    send("X");
    w0 = wr_cnt;
    for (int k = 0; k < 17; k++) send_str($sformatf("%08h", k));
    idle(3);
    chk("ovf_writes", 32'(wr_cnt - w0), 32'd16);
    chk("ovf_first_addr", 32'(wr_addr[w0]), 32'd0);
    chk("ovf_last_addr", 32'(wr_addr[w0+15]), 32'd15);
    chk("ovf_last_data", wr_data[w0+15], 32'd15);
    chk("ovf_wl", 32'(words_loaded), 32'd16);
    chk("ovf_err", 32'(err), 32'd1);
    send("X");
    idle(1);
    chk("ovf_clear_err", 32'(err), 32'd0);
    chk("ovf_clear_wl", 32'(words_loaded), 32'd0);

    // Transmitter flow control.
    idle(2);
    c0 = clr_cnt;
    tx_busy = 1'b1;
    rx_data = "A"; rx_rdy = 1'b1;
`ifdef BOOT_ECHO_EN
    idle(5);
    chk("busy_no_clr", 32'(clr_cnt - c0), 32'd0);
    tx_busy = 1'b0;
    #1;
    chk("busy_release_clr", 32'(rx_clr), 32'd1);
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    chk("busy_echo_wr", 32'(tx_wr), 32'd1);
    chk("busy_echo_data", 32'(tx_data), 32'h41);
`else
    #1;
    chk("nobusy_dep_clr", 32'(rx_clr), 32'd1);
    @(posedge clk); #1;
    rx_rdy = 1'b0; tx_busy = 1'b0;
    chk("noecho_tx_wr", 32'(tx_wr), 32'd0);
    chk("noecho_tx_data", 32'(tx_data), 32'd0);
`endif
    send("X");

    // Asynchronous reset while running drops cpu_start without a clock edge.
    send("G");
    chk("arst_running", 32'(cpu_start), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_start_low", 32'(cpu_start), 32'd0);
    chk("arst_wl", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/uart_boot_sequencer.md
Name: uart_boot_sequencer

Overview:
Controls program load and CPU run for the UART-attached 5-stage CPU. It consumes received bytes from the UART, decodes ASCII hex into 32-bit instruction words and writes them sequentially into instruction memory. It echoes accepted bytes on the UART transmitter, and starts/stops the CPU on host command characters. It is the sole owner of the imem write port, the UART rdy_clr strobe and the UART transmit strobe.

Parameters:
IMEM_DEPTH, 16, number of 32-bit instruction words; imem_addr width is clog2(IMEM_DEPTH).
NIBBLES, 8, hex digits per word; fixed at 8 for 32-bit words.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  UART received byte (dout)
rx_rdy  in  1  UART byte-valid flag, held until rx_clr
rx_clr  out  1  one-cycle pulse; consumes the current byte
tx_data  out  8  byte to transmit
tx_wr  out  1  one-cycle transmit strobe
tx_busy  in  1  UART transmitter busy
imem_we  out  1  one-cycle instruction-memory write enable
imem_addr  out  clog2(IMEM_DEPTH)  write word index
imem_wdata  out  32  assembled instruction word
cpu_halted  in  1  CPU halt flag (ebreak retired)
cpu_start  out  1  CPU run enable; 0 holds the CPU in reset/clear
words_loaded  out  clog2(IMEM_DEPTH)+1  count of words written since last clear
err  out  1  sticky error: bad character or overflow

Behaviour:
- Reset (async, rst_n=0): state LOAD, all outputs 0, nibble counter 0, shift register 0, write pointer 0.
- The block accepts a byte only when rx_rdy=1, tx_busy=0 and no tx_wr or imem_we is pending. Accepting a byte pulses rx_clr for exactly one cycle in the accept cycle.
- Hex decode: 0x30-0x39 map to 0-9, 0x41-0x46 map to A-F, 0x61-0x66 map to a-f.
- States: LOAD, WRITE, RUN, DONE.
- LOAD state:
  - Hex digit: shift the word left 4, insert the nibble at [3:0], increment the nibble count.
  - On the 8th digit, go to WRITE. The first digit received is bits [31:28].
  - 0x0A / 0x0D / 0x20: ignored, but still consumed and echoed.
  - 'G' (0x47): if the nibble count is 0, go to RUN. Otherwise set err, discard the partial word and stay in LOAD.
  - 'X' (0x58): clear the write pointer, words_loaded, the nibble count and err.
  - Any other byte: set err, discard the partial word.
- WRITE state (1 cycle):
  - imem_we=1, imem_addr=pointer, imem_wdata=word.
  - If pointer < IMEM_DEPTH: increment the pointer and words_loaded.
  - If pointer == IMEM_DEPTH (full): suppress imem_we and set err; no wrap-around.
  - Reset the nibble count, return to LOAD.
- RUN state:
  - cpu_start=1 from the cycle after the 'G' accept.
  - A received 'S' (0x53) drops cpu_start the next cycle and returns to LOAD with the pointer retained; other bytes are consumed and ignored.
  - cpu_halted=1 goes to DONE.
- DONE state: cpu_start stays 1 so the CPU's result register stays visible. 'S' returns to LOAD with cpu_start=0. 'G' drops cpu_start for exactly 1 cycle, then re-asserts it (restart).
- Simultaneous events: cpu_halted and 'S' in the same cycle → 'S' wins (LOAD).
- rst_n during RUN drops cpu_start immediately, asynchronously.

Optional Feature:
Macro BOOT_ECHO_EN.
- Defined: every accepted byte is echoed; tx_data=byte and tx_wr=1 in the cycle after accept. Entry to DONE additionally sends 0x21 ('!') once, when tx_busy=0.
- Undefined: tx_wr is tied 0 and tx_data is tied 0. Bytes are accepted without any tx_busy dependency.

Test Plan:
- Load "00100093" then 'G' → imem_we pulse, addr 0, wdata 0x00100093; words_loaded=1; cpu_start=1 one cycle after the 'G' rx_clr.
- Lowercase "deadbeef" plus CR/LF → one write, wdata 0xDEADBEEF; err=0.
- 17 full words with IMEM_DEPTH=16 → 16 writes (addr 0-15); 17th write suppressed; err=1; 'X' clears err and words_loaded to 0.
- "12Z" → err=1, partial word discarded; a following "0000000F" writes 0x0000000F.
- In RUN, assert cpu_halted → DONE, cpu_start remains 1, '!' transmitted (BOOT_ECHO_EN); then 'S' → cpu_start=0, state LOAD.
- Hold tx_busy=1 with rx_rdy=1 → no rx_clr, no state change; release tx_busy → byte accepted, echo tx_wr one cycle later.
